// File: rtl/calibration_interp_if.sv
// Request/result handshake and LUT read port of the calibration interpolation stage.
interface calibration_interp_if #(
    parameter int M = 16,
    parameter int N = 16
);
    logic                start;
    logic signed [M-1:0] X;
    logic [3:0]          pos;
    logic [3:0]          lut_addr;
    logic [M+N-1:0]      lut_data;
    logic                ready;
    logic signed [N-1:0] Y;
    logic                clamped;

    modport master (output start, X, pos, lut_data, input lut_addr, ready, Y, clamped);
    modport slave  (input start, X, pos, lut_data, output lut_addr, ready, Y, clamped);
endinterface

// File: rtl/calibration_interp.sv
// Linear interpolation between LUT entries pos and pos+1 using a restoring divider.
// Define CALIB_INTERP_ROUND_EN to round half up instead of truncating the final shift.
module calibration_interp #(
    parameter int M    = 16,
    parameter int N    = 16,
    parameter int FRAC = 16
) (
    input logic                 clock,
    input logic                 reset,
    calibration_interp_if.slave bus
);
    localparam int PW = N + FRAC + 2;
    localparam int CW = $clog2(FRAC + 1);

    typedef enum logic [2:0] {IDLE, RDA, RDB, CHECK, DIV, MUL, DONE} state_t;

    state_t              state, state_d;
    logic signed [M-1:0] x_q, xa, xb;
    logic signed [N-1:0] ya, yb, res, interp;
    logic [3:0]          pos_q;
    logic [M:0]          rem, dvs, x_off, x_span, rem_d;
    logic [M+1:0]        rem_sh;
    logic [FRAC-1:0]     quo;
    logic [CW-1:0]       cnt;
    logic                res_clamped, clamp_lo, clamp_hi, q_bit;
    logic signed [N:0]   dy;
    logic signed [PW-1:0] prod, prod_r;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (bus.start) state_d = RDA;
            RDA:     state_d = RDB;
            RDB:     state_d = CHECK;
            CHECK:   state_d = (clamp_lo || clamp_hi) ? DONE : DIV;
            DIV:     if (cnt == CW'(FRAC - 1)) state_d = MUL;
            MUL:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clamp_lo = (pos_q == 4'd15) || (x_q <= xa) || (xb <= xa);
        clamp_hi = (x_q >= xb);
        x_off    = (M+1)'(x_q) - (M+1)'(xa);
        x_span   = (M+1)'(xb) - (M+1)'(xa);
        // Integer part of the quotient is zero, so the divider starts from X-xa and shifts in zeros.
        rem_sh   = {rem, 1'b0};
        q_bit    = (rem_sh >= {1'b0, dvs});
        rem_d    = q_bit ? (M+1)'(rem_sh - {1'b0, dvs}) : rem_sh[M:0];
        dy       = (N+1)'(yb) - (N+1)'(ya);
        prod     = PW'(dy) * PW'($signed({1'b0, quo}));
`ifdef CALIB_INTERP_ROUND_EN
        prod_r   = prod + (PW'(1) <<< (FRAC - 1));
`else
        prod_r   = prod;
`endif
        interp   = N'(PW'(ya) + (prod_r >>> FRAC));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q          <= '0;
            pos_q        <= '0;
            xa           <= '0;
            xb           <= '0;
            ya           <= '0;
            yb           <= '0;
            rem          <= '0;
            dvs          <= '0;
            quo          <= '0;
            cnt          <= '0;
            res          <= '0;
            res_clamped  <= 1'b0;
            bus.lut_addr <= '0;
            bus.ready    <= 1'b0;
            bus.Y        <= '0;
            bus.clamped  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    x_q          <= bus.X;
                    pos_q        <= bus.pos;
                    bus.lut_addr <= bus.pos;
                    bus.ready    <= 1'b0;
                end
                RDA: begin
                    xa           <= bus.lut_data[M+N-1:N];
                    ya           <= bus.lut_data[N-1:0];
                    bus.lut_addr <= (pos_q == 4'd15) ? 4'd15 : pos_q + 4'd1;
                end
                RDB: begin
                    xb <= bus.lut_data[M+N-1:N];
                    yb <= bus.lut_data[N-1:0];
                end
                CHECK: begin
                    if (clamp_lo) begin
                        res         <= ya;
                        res_clamped <= 1'b1;
                    end else if (clamp_hi) begin
                        res         <= yb;
                        res_clamped <= 1'b1;
                    end else begin
                        rem <= x_off;
                        dvs <= x_span;
                        quo <= '0;
                        cnt <= '0;
                    end
                end
                DIV: begin
                    rem <= rem_d;
                    quo <= {quo[FRAC-2:0], q_bit};
                    cnt <= cnt + CW'(1);
                end
                MUL: begin
                    res         <= interp;
                    res_clamped <= 1'b0;
                end
                DONE: begin
                    // Result is staged so Y, clamped and ready all change on the same edge.
                    bus.Y       <= res;
                    bus.clamped <= res_clamped;
                    bus.ready   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calibration_interp.sv
// Directed-vector bench for calibration_interp with a behavioural LUT.
module tb_calibration_interp;
    localparam int M    = 16;
    localparam int N    = 16;
    localparam int FRAC = 16;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [M+N-1:0] lut [16];
    int             n_vec = 0;
    int             n_err = 0;

    calibration_interp_if #(.M(M), .N(N)) bus ();

    calibration_interp #(.M(M), .N(N), .FRAC(FRAC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    assign bus.lut_data = lut[bus.lut_addr];

    // Starts one conversion and returns edges from acceptance to ready, or -1 on timeout.
    task automatic run_conv(input logic [15:0] x, input logic [3:0] p, output int lat);
        bus.X     = x;
        bus.pos   = p;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        lat = 0;
        while (bus.ready !== 1'b1 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        if (bus.ready !== 1'b1) lat = -1;
    endtask

    task automatic set_positive_pair();
        lut[3] = {16'h0100, 16'h1000};
        lut[4] = {16'h0200, 16'h2000};
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.X     = '0;
        bus.pos   = '0;
        for (int i = 0; i < 16; i++) lut[i] = {16'(i * 256), 16'(i * 4096)};
        #2 reset = 1'b0;
        #10;
        n_vec++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
        n_vec++; if (bus.Y !== 16'h0000) begin n_err++; $display("FAIL reset_y: got %h want 0000", bus.Y); end
        n_vec++; if (bus.clamped !== 1'b0) begin n_err++; $display("FAIL reset_clamped: got %b want 0", bus.clamped); end
        n_vec++; if (bus.lut_addr !== 4'd0) begin n_err++; $display("FAIL reset_lut_addr: got %0d want 0", bus.lut_addr); end
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        n_vec++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL post_reset_ready: got %b want 0", bus.ready); end
    endtask

    task automatic test_interp();
        int lat;
        set_positive_pair();
        run_conv(16'h0180, 4'd3, lat);
        n_vec++; if (lat !== 21) begin n_err++; $display("FAIL interp_latency: got %0d want 21", lat); end
        n_vec++; if (bus.Y !== 16'h1800) begin n_err++; $display("FAIL interp_y: got %h want 1800", bus.Y); end
        n_vec++; if (bus.clamped !== 1'b0) begin n_err++; $display("FAIL interp_clamped: got %b want 0", bus.clamped); end
        n_vec++; if (bus.lut_addr !== 4'd4) begin n_err++; $display("FAIL interp_lut_addr: got %0d want 4", bus.lut_addr); end
        // Bracket straddling zero: xa=-256, xb=256, ya=-4096, yb=4096, X=0 -> Y=0.
        lut[5] = {16'hFF00, 16'hF000};
        lut[6] = {16'h0100, 16'h1000};
        run_conv(16'h0000, 4'd5, lat);
        n_vec++; if (lat !== 21) begin n_err++; $display("FAIL signed_latency: got %0d want 21", lat); end
        n_vec++; if (bus.Y !== 16'h0000) begin n_err++; $display("FAIL signed_y: got %h want 0000", bus.Y); end
    endtask

    task automatic test_neg_slope();
        int lat;
        lut[3] = {16'h0100, 16'h2000};
        lut[4] = {16'h0200, 16'h1000};
        run_conv(16'h0140, 4'd3, lat);
        n_vec++; if (lat !== 21) begin n_err++; $display("FAIL neg_latency: got %0d want 21", lat); end
        n_vec++; if (bus.Y !== 16'h1C00) begin n_err++; $display("FAIL neg_y: got %h want 1c00", bus.Y); end
        n_vec++; if (bus.clamped !== 1'b0) begin n_err++; $display("FAIL neg_clamped: got %b want 0", bus.clamped); end
    endtask

    task automatic test_clamp();
        int          lat;
        logic [15:0] xs   [7] = '{16'h0100, 16'h0250, 16'h0080, 16'h0200, 16'h7FFF, 16'h8000, 16'h0350};
        logic [3:0]  ps   [7] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd15, 4'd15, 4'd7};
        logic [15:0] ys   [7] = '{16'h1000, 16'h2000, 16'h1000, 16'h2000, 16'h1234, 16'h1234, 16'h0055};
        set_positive_pair();
        lut[15] = {16'h7000, 16'h1234};
        lut[7]  = {16'h0300, 16'h0055};
        lut[8]  = {16'h0280, 16'h0066};
        for (int i = 0; i < 7; i++) begin
            run_conv(xs[i], ps[i], lat);
            n_vec++; if (lat !== 4) begin n_err++; $display("FAIL clamp_latency[%0d]: got %0d want 4", i, lat); end
            n_vec++; if (bus.Y !== ys[i]) begin n_err++; $display("FAIL clamp_y[%0d]: got %h want %h", i, bus.Y, ys[i]); end
            n_vec++; if (bus.clamped !== 1'b1) begin n_err++; $display("FAIL clamp_flag[%0d]: got %b want 1", i, bus.clamped); end
            if (ps[i] == 4'd15) begin
                n_vec++; if (bus.lut_addr !== 4'd15) begin n_err++; $display("FAIL clamp_top_addr[%0d]: got %0d want 15", i, bus.lut_addr); end
            end
        end
    endtask

    task automatic test_rounding();
        int          lat;
        logic [15:0] exp_y;
`ifdef CALIB_INTERP_ROUND_EN
        exp_y = 16'h0001;
`else
        exp_y = 16'h0000;
`endif
        lut[3] = {16'h0100, 16'h0000};
        lut[4] = {16'h0103, 16'h0002};
        run_conv(16'h0101, 4'd3, lat);
        n_vec++; if (lat !== 21) begin n_err++; $display("FAIL round_latency: got %0d want 21", lat); end
        n_vec++; if (bus.Y !== exp_y) begin n_err++; $display("FAIL round_y: got %h want %h", bus.Y, exp_y); end
        n_vec++; if (bus.clamped !== 1'b0) begin n_err++; $display("FAIL round_clamped: got %b want 0", bus.clamped); end
    endtask

    task automatic test_busy_start();
        int   lat = -1;
        int   completions = 0;
        logic prev_ready = 1'b0;
        set_positive_pair();
        bus.X     = 16'h0180;
        bus.pos   = 4'd3;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc == 5) begin
                bus.X     = 16'h0100;
                bus.start = 1'b1;
            end
            @(posedge clock); #1;
            if (cyc == 5) bus.start = 1'b0;
            if (bus.ready === 1'b1 && prev_ready !== 1'b1) begin
                completions++;
                if (lat < 0) lat = cyc;
            end
            prev_ready = bus.ready;
        end
        n_vec++; if (completions !== 1) begin n_err++; $display("FAIL busy_completions: got %0d want 1", completions); end
        n_vec++; if (lat !== 21) begin n_err++; $display("FAIL busy_latency: got %0d want 21", lat); end
        n_vec++; if (bus.Y !== 16'h1800) begin n_err++; $display("FAIL busy_y: got %h want 1800", bus.Y); end
    endtask

    task automatic test_reset_mid();
        int lat;
        set_positive_pair();
        bus.X     = 16'h0180;
        bus.pos   = 4'd3;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        n_vec++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b want 0", bus.ready); end
        n_vec++; if (bus.Y !== 16'h0000) begin n_err++; $display("FAIL midrst_y: got %h want 0000", bus.Y); end
        n_vec++; if (bus.lut_addr !== 4'd0) begin n_err++; $display("FAIL midrst_lut_addr: got %0d want 0", bus.lut_addr); end
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        repeat (25) @(posedge clock);
        #1;
        n_vec++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL midrst_no_result: got %b want 0", bus.ready); end
        run_conv(16'h01C0, 4'd3, lat);
        n_vec++; if (lat !== 21) begin n_err++; $display("FAIL midrst_fresh_latency: got %0d want 21", lat); end
        n_vec++; if (bus.Y !== 16'h1C00) begin n_err++; $display("FAIL midrst_fresh_y: got %h want 1c00", bus.Y); end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [15:0] y_prev = 16'h1C00;
        logic [15:0] xs [3] = '{16'h0100, 16'h0300, 16'h0140};
        logic [15:0] ys [3] = '{16'h1000, 16'h2000, 16'h1400};
        int          ls [3] = '{4, 4, 21};
        logic        cs [3] = '{1'b1, 1'b1, 1'b0};
        set_positive_pair();
        bus.pos   = 4'd3;
        bus.X     = xs[0];
        bus.start = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept[%0d]: got ready %b want 0", i, bus.ready); end
            if (i < 2) bus.X = xs[i+1];
            lat = 0;
            while (bus.ready !== 1'b1 && lat < 100) begin
                n_vec++; if (bus.Y !== y_prev) begin n_err++; $display("FAIL b2b_hold[%0d]: got %h want %h", i, bus.Y, y_prev); end
                @(posedge clock); #1;
                lat++;
            end
            n_vec++; if (lat !== ls[i]) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, ls[i]); end
            n_vec++; if (bus.Y !== ys[i]) begin n_err++; $display("FAIL b2b_y[%0d]: got %h want %h", i, bus.Y, ys[i]); end
            n_vec++; if (bus.clamped !== cs[i]) begin n_err++; $display("FAIL b2b_clamped[%0d]: got %b want %b", i, bus.clamped, cs[i]); end
            y_prev = ys[i];
            if (i == 2) bus.start = 1'b0;
            @(posedge clock); #1;
        end
        n_vec++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle_ready: got %b want 1", bus.ready); end
    endtask

    initial begin
        test_reset();
        test_interp();
        test_neg_slope();
        test_clamp();
        test_rounding();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
